// File: rtl/imm_operand_encoder.sv
// Iterative encoder: finds the {rotate_imm, immed_8} operand whose rotated decode equals a
// 32-bit constant, optionally retrying on its bitwise NOT and its negation.
module imm_operand_encoder #(
    parameter bit ALLOW_NOT = 1'b1,
    parameter bit ALLOW_NEG = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_value,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_found,
    output logic [11:0] o_shift_operand,
    output logic [1:0]  o_variant
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] C_DIRECT = 2'b00;
    localparam logic [1:0] C_NOT    = 2'b01;
    localparam logic [1:0] C_NEG    = 2'b10;

    state_t      r_state;
    logic [31:0] r_value;
    logic [1:0]  r_cand;
    logic [3:0]  r_rot;
    logic        r_busy;
    logic        r_done;
    logic        r_found;
    logic [11:0] r_shift_operand;
    logic [1:0]  r_variant;

    logic [31:0] w_cand_val;
    logic [5:0]  w_sh;
    logic [31:0] w_rol;
    logic        w_match;
    logic        w_has_next;
    logic [1:0]  w_next_cand;

    always_comb begin
        w_cand_val = r_value;
        case (r_cand)
            C_NOT:   w_cand_val = ~r_value;
            C_NEG:   w_cand_val = 32'd0 - r_value;
            default: w_cand_val = r_value;
        endcase
    end

    // Rotating the constant left undoes the decoder's right rotation; at r=0 the
    // right-shift term is by 32 and contributes nothing.
    assign w_sh    = {1'b0, r_rot, 1'b0};
    assign w_rol   = (w_cand_val << w_sh) | (w_cand_val >> (6'd32 - w_sh));
    assign w_match = (w_rol[31:8] == 24'd0);

    always_comb begin
        w_has_next  = 1'b0;
        w_next_cand = C_DIRECT;
        case (r_cand)
            C_DIRECT: begin
                if (ALLOW_NOT) begin
                    w_has_next  = 1'b1;
                    w_next_cand = C_NOT;
                end else if (ALLOW_NEG) begin
                    w_has_next  = 1'b1;
                    w_next_cand = C_NEG;
                end
            end
            C_NOT: begin
                if (ALLOW_NEG) begin
                    w_has_next  = 1'b1;
                    w_next_cand = C_NEG;
                end
            end
            default: begin
                w_has_next  = 1'b0;
                w_next_cand = C_DIRECT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_value         <= 32'd0;
            r_cand          <= C_DIRECT;
            r_rot           <= 4'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_found         <= 1'b0;
            r_shift_operand <= 12'd0;
            r_variant       <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_value <= i_value;
                        r_cand  <= C_DIRECT;
                        r_rot   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SEARCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SEARCH: begin
                    if (w_match) begin
                        r_found         <= 1'b1;
                        r_shift_operand <= {r_rot, w_rol[7:0]};
                        r_variant       <= r_cand;
                        r_busy          <= 1'b0;
                        r_done          <= 1'b1;
                        r_state         <= S_DONE;
                    end else if (r_rot == 4'd15) begin
                        if (w_has_next) begin
                            r_cand <= w_next_cand;
                            r_rot  <= 4'd0;
                        end else begin
                            r_found         <= 1'b0;
                            r_shift_operand <= 12'd0;
                            r_variant       <= 2'b00;
                            r_busy          <= 1'b0;
                            r_done          <= 1'b1;
                            r_state         <= S_DONE;
                        end
                    end else begin
                        r_rot <= r_rot + 4'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_found         = r_found;
    assign o_shift_operand = r_shift_operand;
    assign o_variant       = r_variant;

endmodule
